// File: rtl/temperature_scan_ctrl_if.sv
// Shared request/acknowledge port between the scan controller and the sensor bank.
// The controller drives select/request; the selected sensor answers with ack/data.
interface temperature_scan_ctrl_if;
  logic [2:0] sensor_sel_o;
  logic       sensor_req_o;
  logic       sensor_ack_i;
  logic [7:0] sensor_data_i;

  modport master (
    output sensor_sel_o,
    output sensor_req_o,
    input  sensor_ack_i,
    input  sensor_data_i
  );

  modport slave (
    input  sensor_sel_o,
    input  sensor_req_o,
    output sensor_ack_i,
    output sensor_data_i
  );
endinterface

// File: rtl/temperature_scan_ctrl.sv
// Polls up to five sensors over a shared 8-bit port, accumulates the readings,
// then divides by the responder count with a 16-cycle restoring divider.
module temperature_scan_ctrl #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd64
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           start_i,
  input  logic [4:0]                     sensors_en_i,
  temperature_scan_ctrl_if.master        sensor_bus,
  output logic                           busy_o,
  output logic                           result_valid_o,
  output logic [15:0]                    avg_o,
  output logic [15:0]                    rem_o,
  output logic [7:0]                     nr_sensors_o,
  output logic [4:0]                     timeout_o,
  output logic                           no_sensor_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_REQ  = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t      state_r;
  logic [4:0]  en_r;
  logic [2:0]  idx_r;
  logic [15:0] sum_r;
  logic [2:0]  cnt_r;
  logic [7:0]  wait_r;
  logic [15:0] dvd_r;
  logic [15:0] part_r;
  logic [3:0]  step_r;
  logic        req_r;
  logic        busy_r;
  logic        valid_r;
  logic        no_sensor_r;
  logic [15:0] avg_r;
  logic [15:0] rem_r;
  logic [7:0]  nr_r;
  logic [4:0]  to_r;

  logic        acc_s;
  logic [15:0] sum_nxt_s;
  logic [2:0]  cnt_nxt_s;
  logic        last_s;
  state_t      adv_state_s;
  logic [2:0]  adv_idx_s;
  logic [16:0] divisor_s;
  logic [16:0] shift_s;
  logic [16:0] diff_s;
  logic        fit_s;

  // Accumulator update, next-sensor selection and one restoring-divide step.
  always_comb begin
    acc_s     = (state_r == ST_REQ) && sensor_bus.sensor_ack_i;
    sum_nxt_s = acc_s ? (sum_r + {8'd0, sensor_bus.sensor_data_i}) : sum_r;
    cnt_nxt_s = acc_s ? (cnt_r + 3'd1) : cnt_r;
    last_s    = (idx_r == 3'd4);
    if (last_s) begin
      adv_idx_s   = idx_r;
      adv_state_s = (cnt_nxt_s == 3'd0) ? ST_DONE : ST_DIV;
    end else begin
      adv_idx_s   = idx_r + 3'd1;
      adv_state_s = ST_SCAN;
    end
    divisor_s = {14'd0, cnt_r};
    shift_s   = {part_r, dvd_r[15]};
    diff_s    = shift_s - divisor_s;
    // No borrow out of the trial subtraction means the divisor fits.
    fit_s     = ~diff_s[16];
  end

  // Controller state, datapath registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      en_r        <= 5'd0;
      idx_r       <= 3'd0;
      sum_r       <= 16'd0;
      cnt_r       <= 3'd0;
      wait_r      <= 8'd0;
      dvd_r       <= 16'd0;
      part_r      <= 16'd0;
      step_r      <= 4'd0;
      req_r       <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      no_sensor_r <= 1'b0;
      avg_r       <= 16'd0;
      rem_r       <= 16'd0;
      nr_r        <= 8'd0;
      to_r        <= 5'd0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            sum_r   <= 16'd0;
            cnt_r   <= 3'd0;
            idx_r   <= 3'd0;
            to_r    <= 5'd0;
            en_r    <= sensors_en_i;
            busy_r  <= 1'b1;
            state_r <= ST_SCAN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (en_r[idx_r]) begin
            req_r   <= 1'b1;
            wait_r  <= 8'd1;
            state_r <= ST_REQ;
          end else begin
            idx_r   <= adv_idx_s;
            state_r <= adv_state_s;
            dvd_r   <= sum_nxt_s;
            part_r  <= 16'd0;
            step_r  <= 4'd0;
          end
        end
        ST_REQ: begin
          // An ack on the final wait cycle still counts as an answer.
          if (acc_s || (wait_r == TIMEOUT_CYCLES)) begin
            sum_r   <= sum_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (!acc_s) begin
              to_r[idx_r] <= 1'b1;
            end else begin
              to_r[idx_r] <= to_r[idx_r];
            end
            req_r   <= 1'b0;
            idx_r   <= adv_idx_s;
            state_r <= adv_state_s;
            dvd_r   <= sum_nxt_s;
            part_r  <= 16'd0;
            step_r  <= 4'd0;
          end else begin
            wait_r  <= wait_r + 8'd1;
          end
        end
        ST_DIV: begin
          dvd_r  <= {dvd_r[14:0], fit_s};
          part_r <= fit_s ? diff_s[15:0] : shift_s[15:0];
          step_r <= step_r + 4'd1;
          if (step_r == 4'd15) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_DONE: begin
          nr_r    <= {5'd0, cnt_r};
          if (cnt_r == 3'd0) begin
            avg_r       <= 16'd0;
            rem_r       <= 16'd0;
            no_sensor_r <= 1'b1;
          end else begin
            avg_r       <= dvd_r;
            rem_r       <= part_r;
            no_sensor_r <= 1'b0;
          end
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sensor_bus.sensor_sel_o = idx_r;
  assign sensor_bus.sensor_req_o = req_r;
  assign busy_o                  = busy_r;
  assign result_valid_o          = valid_r;
  assign avg_o                   = avg_r;
  assign rem_o                   = rem_r;
  assign nr_sensors_o            = nr_r;
  assign timeout_o               = to_r;
  assign no_sensor_o             = no_sensor_r;

endmodule

// File: tb/tb_temperature_scan_ctrl.sv
// Table-driven bench for temperature_scan_ctrl with a behavioural sensor bank
// and an expected-result queue popped on every result_valid_o pulse.
module tb_temperature_scan_ctrl;

  localparam logic [7:0] TO_CYC = 8'd4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  en;
  logic        busy;
  logic        rv;
  logic [15:0] avg;
  logic [15:0] rem;
  logic [7:0]  nr;
  logic [4:0]  tmo;
  logic        nos;

  temperature_scan_ctrl_if bus ();

  temperature_scan_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .sensors_en_i   (en),
    .sensor_bus     (bus),
    .busy_o         (busy),
    .result_valid_o (rv),
    .avg_o          (avg),
    .rem_o          (rem),
    .nr_sensors_o   (nr),
    .timeout_o      (tmo),
    .no_sensor_o    (nos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      en;
    logic [4:0][7:0] data;
    logic [4:0][7:0] dly;    // REQ cycle of the ack, 0 = never answers
    logic            spur;   // drive ack whenever no request is pending
    logic            tog;    // invert sensors_en_i after the start edge
    int              pulse;  // cycle of an extra start pulse, 0 = none
    logic [15:0]     avg;
    logic [15:0]     rem;
    logic [7:0]      nr;
    logic [4:0]      tmo;
    logic            nos;
    int              lat;
    int              reqc;
  } vec_t;

  vec_t vecs [10];
  vec_t exp_q [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] e, input logic [39:0] d, input logic [39:0] w,
                              input logic sp, input logic tg, input int pl,
                              input logic [15:0] a, input logic [15:0] r, input logic [7:0] n,
                              input logic [4:0] t, input logic ns, input int lt, input int rc);
    vec_t v;
    v.en = e; v.data = d; v.dly = w; v.spur = sp; v.tog = tg; v.pulse = pl;
    v.avg = a; v.rem = r; v.nr = n; v.tmo = t; v.nos = ns; v.lat = lt; v.reqc = rc;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    vec_t e;
    bit   done;
    bit   prev_req;
    int   reqcnt;
    int   reqtot;
    int   sel;
    exp_q.push_back(v);
    @(negedge clk);
    en    = v.en;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d busy_rise", id), {31'd0, busy}, 32'd1);
    start = 1'b0;
    if (v.tog) en = ~v.en;
    done = 1'b0; prev_req = 1'b0; reqcnt = 0; reqtot = 0;
    for (int c = 1; c <= 400 && !done; c++) begin
      @(negedge clk);
      if (bus.sensor_req_o) begin
        sel    = int'(bus.sensor_sel_o);
        reqcnt = prev_req ? reqcnt + 1 : 1;
        reqtot++;
        if (!prev_req) chk($sformatf("v%0d sel_enabled", id), {31'd0, v.en[sel]}, 32'd1);
        if (sel <= 4 && v.dly[sel] != 8'd0 && reqcnt == int'(v.dly[sel])) begin
          bus.sensor_ack_i  = 1'b1;
          bus.sensor_data_i = v.data[sel];
        end else begin
          bus.sensor_ack_i  = 1'b0;
          bus.sensor_data_i = 8'($urandom_range(0, 255));
        end
      end else begin
        reqcnt = 0;
        bus.sensor_ack_i  = v.spur;
        bus.sensor_data_i = 8'hFF;
      end
      prev_req = bus.sensor_req_o;
      start    = (c == v.pulse);
      @(posedge clk);
      #1;
      if (rv) begin
        done = 1'b1;
        chk($sformatf("v%0d latency", id), c, v.lat);
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d queue_empty", id), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d avg", id), {16'd0, avg}, {16'd0, e.avg});
          chk($sformatf("v%0d rem", id), {16'd0, rem}, {16'd0, e.rem});
          chk($sformatf("v%0d nr", id), {24'd0, nr}, {24'd0, e.nr});
          chk($sformatf("v%0d timeout", id), {27'd0, tmo}, {27'd0, e.tmo});
          chk($sformatf("v%0d no_sensor", id), {31'd0, nos}, {31'd0, e.nos});
          chk($sformatf("v%0d busy_fall", id), {31'd0, busy}, 32'd0);
          chk($sformatf("v%0d req_cycles", id), reqtot, v.reqc);
        end
      end
    end
    if (!done) chk($sformatf("v%0d result_seen", id), 32'd0, 32'd1);
    @(negedge clk);
    bus.sensor_ack_i = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d idle_after", id), {30'd0, busy, rv}, 32'd0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0; en = 5'd0;
    bus.sensor_ack_i = 1'b0; bus.sensor_data_i = 8'd0;

    //        en        data {s4..s0}                  dly {s4..s0}             sp    tg    pl  avg  rem nr tmo       nos  lat reqc
    vecs[0] = mk(5'b11111, {8'd24,8'd23,8'd22,8'd21,8'd20}, {8'd1,8'd1,8'd1,8'd1,8'd1}, 1'b0, 1'b0, 0, 16'd22, 16'd0, 8'd5, 5'b00000, 1'b0, 27, 5);
    vecs[1] = mk(5'b10101, {8'd35,8'd0,8'd31,8'd0,8'd30},   {8'd1,8'd0,8'd1,8'd0,8'd1}, 1'b0, 1'b0, 0, 16'd32, 16'd0, 8'd3, 5'b00000, 1'b0, 25, 3);
    vecs[2] = mk(5'b10101, {8'd34,8'd0,8'd31,8'd0,8'd30},   {8'd1,8'd0,8'd1,8'd0,8'd1}, 1'b0, 1'b0, 0, 16'd31, 16'd2, 8'd3, 5'b00000, 1'b0, 25, 3);
    vecs[3] = mk(5'b00000, 40'd0,                           40'd0,                      1'b0, 1'b0, 0, 16'd0,  16'd0, 8'd0, 5'b00000, 1'b1, 6,  0);
    vecs[4] = mk(5'b11111, {8'd40,8'd40,8'd40,8'd40,8'd40}, {8'd1,8'd1,8'd1,8'd0,8'd1}, 1'b0, 1'b0, 0, 16'd40, 16'd0, 8'd4, 5'b00010, 1'b0, 30, 8);
    vecs[5] = mk(5'b00011, {8'd0,8'd0,8'd0,8'd10,8'd77},    {8'd0,8'd0,8'd0,8'd2,8'd4}, 1'b0, 1'b0, 0, 16'd43, 16'd1, 8'd2, 5'b00000, 1'b0, 28, 6);
    vecs[6] = mk(5'b01010, {8'd0,8'd7,8'd0,8'd100,8'd0},    {8'd0,8'd1,8'd0,8'd3,8'd0}, 1'b1, 1'b1, 0, 16'd53, 16'd1, 8'd2, 5'b00000, 1'b0, 26, 4);
    vecs[7] = mk(5'b00100, {8'd0,8'd0,8'd99,8'd0,8'd0},     40'd0,                      1'b0, 1'b0, 0, 16'd0,  16'd0, 8'd0, 5'b00100, 1'b1, 10, 4);
    vecs[8] = mk(5'b11111, {8'd255,8'd255,8'd255,8'd255,8'd254}, {8'd4,8'd3,8'd2,8'd1,8'd1}, 1'b0, 1'b0, 0, 16'd254, 16'd4, 8'd5, 5'b00000, 1'b0, 33, 11);
    vecs[9] = mk(5'b11111, {8'd24,8'd23,8'd22,8'd21,8'd20}, {8'd1,8'd1,8'd1,8'd1,8'd1}, 1'b0, 1'b0, 15, 16'd22, 16'd0, 8'd5, 5'b00000, 1'b0, 27, 5);

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy_rv_req", {29'd0, busy, rv, bus.sensor_req_o}, 32'd0);
    chk("rst sel", {29'd0, bus.sensor_sel_o}, 32'd0);
    chk("rst avg_rem", {avg, rem}, 32'd0);
    chk("rst nr_tmo_nos", {18'd0, nr, tmo, nos}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Held start: two empty scans separated by a single IDLE cycle.
    @(negedge clk);
    en = 5'd0; start = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    chk("held first_rv", {30'd0, rv, busy}, 32'd2);
    chk("held no_sensor", {31'd0, nos}, 32'd1);
    @(posedge clk);
    #1;
    chk("held retrigger", {30'd0, rv, busy}, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("held second_rv", {30'd0, rv, busy}, 32'd2);
    @(posedge clk);
    #1;
    chk("held idle", {30'd0, rv, busy}, 32'd0);

    // Reset while sensor 2 is being requested, sensors 0/1 having timed out.
    @(negedge clk);
    en = 5'b11111; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.sensor_req_o && bus.sensor_sel_o == 3'd2) found = 1'b1;
    end
    chk("rstmid reached_sensor2", {31'd0, found}, 32'd1);
    chk("rstmid timeout_before", {27'd0, tmo}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid req_async", {31'd0, bus.sensor_req_o}, 32'd0);
    chk("rstmid busy_sel", {28'd0, busy, bus.sensor_sel_o}, 32'd0);
    chk("rstmid outputs", {avg, rem} | {18'd0, nr, tmo, nos} | {31'd0, rv}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temperature_scan_ctrl.md
# temperature_scan_ctrl

Sequential acquisition controller for the temperature monitoring datapath. On a start request it polls up to five sensors one at a time over a shared request/acknowledge port, accumulating the readings and counting the sensors that answered. It then runs a multi-cycle restoring divider and presents the average temperature and remainder, ready for the LED/alert display logic. It replaces the flat 40-bit parallel sensor bus with a single shared 8-bit sensor port.

## Interface
- TIMEOUT_CYCLES, 64: maximum REQ cycles per sensor before that sensor is skipped; range 1..255.
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- start_i  input  1  scan request; level-sampled in IDLE only.
- sensors_en_i  input  5  per-sensor enable; snapshotted on the accepted start edge.
- sensor_sel_o  output  3  index (0..4) of the sensor being polled.
- sensor_req_o  output  1  read request to the selected sensor.
- sensor_ack_i  input  1  sensor response strobe; valid only while sensor_req_o=1.
- sensor_data_i  input  8  unsigned reading; sampled on the edge where sensor_ack_i=1 and sensor_req_o=1.
- busy_o  output  1  high in every state except IDLE.
- result_valid_o  output  1  one-cycle pulse when results update.
- avg_o  output  16  quotient sum/count.
- rem_o  output  16  remainder sum mod count.
- nr_sensors_o  output  8  number of sensors that answered, zero-extended.
- timeout_o  output  5  per-sensor timeout flags for the last scan.
- no_sensor_o  output  1  high when the last scan had count=0.

## Operation
- States: IDLE, SCAN, REQ, DIV, DONE.
- **IDLE**
  - start_i=1 → clear sum, count, index and timeout flags, latch sensors_en_i, go to SCAN.
- **SCAN** (index i)
  - Latched enable bit i = 1 → go to REQ.
  - Enable bit i = 0 → advance:
    - i<4 → i+1, stay in SCAN.
    - i=4 → go to DIV, or to DONE when count=0.
- **REQ**
  - sensor_req_o=1 and sensor_sel_o=i for the whole state.
  - Ack seen → sum += data, count += 1, advance as in SCAN.
  - Wait counter reaches TIMEOUT_CYCLES with no ack → set timeout_o[i], reading discarded, advance.
  - Ack on the same edge the counter reaches TIMEOUT_CYCLES → the ack wins; the sensor is not flagged.
- **DIV**
  - Restoring division of the 16-bit sum by the zero-extended count, one quotient bit per cycle, exactly 16 cycles, MSB first.
- **DONE**
  - Load avg_o, rem_o, nr_sensors_o and no_sensor_o.
  - Assert result_valid_o for this cycle, then return to IDLE.
  - count=0 → avg_o=0, rem_o=0, no_sensor_o=1.
- **Width and data rules**
  - sum is 16 bits; the maximum 5×255=1275 cannot overflow.
  - count is 3 bits internally, presented as 8 bits.
  - Result outputs and timeout_o hold their values until the next DONE. timeout_o bits update as flags are set during the scan.
- **Ignored inputs**
  - start_i outside IDLE is ignored, including while start_i is held high.
  - A held start_i re-triggers in the IDLE cycle after DONE.
  - sensor_ack_i outside REQ is ignored.
  - sensors_en_i changes during a scan have no effect.

## Timing
- **Reset values**
  - State IDLE; all outputs 0 (sensor_sel_o=0, sensor_req_o=0, busy_o=0, result_valid_o=0, avg_o=rem_o=nr_sensors_o=0, timeout_o=0, no_sensor_o=0).
  - Reset asserted mid-scan drops sensor_req_o immediately (asynchronously) and discards the partial scan.
- **Per-sensor cost**
  - Disabled sensor: 1 cycle.
  - Enabled sensor: 1 SCAN cycle + n REQ cycles, where ack arrives in REQ cycle n (n ≥ 1).
  - Timed-out sensor: 1 + TIMEOUT_CYCLES cycles.
- **Request/acknowledge**
  - sensor_req_o deasserts on the edge following the accepted ack.
  - A sensor may hold ack for one cycle only. Any ack seen in a later REQ state belongs to that later request.
- **End-to-end latency** (start accepted at edge 0)
  - busy_o rises after edge 0.
  - result_valid_o is high in the cycle after edge 1 + scan_cycles + 16 (divide) when count>0.
  - When count=0 it is high after edge 1 + scan_cycles, with no divide cycles.
  - busy_o falls together with result_valid_o.

## Test plan
- **All enabled, immediate ack:** en=5'b11111, data 20,21,22,23,24, ack in the first REQ cycle → result_valid_o at cycle 27, avg_o=22, rem_o=0, nr_sensors_o=5, timeout_o=0.
- **Partial enable with remainder:** en=5'b10101, data 30,31,35 → avg_o=32, rem_o=0. Repeat with data 30,31,34 → avg_o=31, rem_o=2, nr_sensors_o=3; sensor_sel_o visits 0, 2, 4 only.
- **None enabled:** en=0 → result_valid_o at cycle 6, no_sensor_o=1, avg_o=0, rem_o=0, sensor_req_o never asserted.
- **Timeout:** TIMEOUT_CYCLES=4, sensor 1 never acks, others ack with 40 → timeout_o=5'b00010, nr_sensors_o=4, avg_o=40. Also check that an ack on the 4th REQ cycle is accepted and not flagged.
- **Protocol robustness:**
  - start_i held high → back-to-back scans with one IDLE cycle between them.
  - start pulse during DIV is ignored.
  - Spurious ack outside REQ does not change sum.
  - sensors_en_i toggled mid-scan has no effect.
- **Reset:** rst_n_i low during REQ of sensor 2 → sensor_req_o falls without a clock edge and all outputs go to 0. After release, a new start gives a correct, clean result.
